// File: rtl/dcm_prog_pkg.sv
// dcm_prog_pkg
// Shared definitions for the DCM_CLKGEN reprogramming sequencer:
//   - state_t     : sequencer state encoding
//   - CMD_LOAD_*  : two-bit command prefixes, shifted out bit0 first
//   - FRAME_LEN   : PROGEN-high length of one load frame (prefix + 8 data bits)
//   - GAP_LEN     : PROGEN-low spacing between frames
//   - build_frame : packs a prefix and an 8-bit value into an LSB-first frame
package dcm_prog_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GATE,
    ST_LOAD_D,
    ST_GAP_D,
    ST_LOAD_M,
    ST_GAP_M,
    ST_GO,
    ST_WAIT_DONE,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RECOVER
  } state_t;

  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  localparam int FRAME_LEN = 10;
  localparam int GAP_LEN   = 2;

  // The prefix sits in the low bits so that a plain right shift sends it
  // first (bit0 of the prefix, then bit1), followed by the value LSB first.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [1:0] cmd,
                                                       input logic [7:0] value);
    return {value, cmd};
  endfunction

endpackage

// File: rtl/dcm_prog_shifter.sv
// dcm_prog_shifter
// Serialises one 10-bit DCM programming frame, LSB first, one bit per clock.
// Ports:
//   clk, rst_n : block clock and asynchronous active-low reset
//   load       : accept frame when not busy; shifting starts next cycle
//   frame      : frame to send, bit0 goes out first
//   busy       : high for exactly FRAME_LEN cycles per frame; used as PROGEN
//   last       : high during the final bit of a frame
//   sdata      : current bit, forced low whenever busy is low
module dcm_prog_shifter
  import dcm_prog_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [FRAME_LEN-1:0] frame,
  output logic                 busy,
  output logic                 last,
  output logic                 sdata
);

  logic [FRAME_LEN-1:0] shreg;
  logic [3:0]           remaining;

  // Shift register plus a down-counter of bits still to send. The async
  // reset clears the counter, which drops busy (and hence PROGEN) at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (load && !busy) begin
      shreg     <= frame;
      remaining <= 4'(FRAME_LEN);
    end else if (busy) begin
      shreg     <= shreg >> 1;
      remaining <= remaining - 4'd1;
    end
  end

  assign busy  = (remaining != 4'd0);
  assign last  = (remaining == 4'd1);
  assign sdata = busy & shreg[0];

endmodule

// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl
// Sequencer for the Spartan-6 DCM_CLKGEN serial programming port. On a host
// request it gates the forwarded 25 MHz clocks, shifts new D and M values into
// the DCM, issues GO, waits for PROGDONE and LOCKED, lets the clock settle and
// re-enables the forwarders. Timeouts trigger one DCM reset retry.
// Ports:
//   clk, rst_n        : clock (also DCM PROGCLK), asynchronous active-low reset
//   cfg_req           : level request, only looked at in IDLE
//   cfg_m_m1/cfg_d_m1 : M-1 / D-1, latched when a request is accepted
//   cfg_ack/cfg_err   : one-cycle completion pulse / failure flag with it
//   busy              : high whenever the sequencer is not idle
//   clk_on_req        : host enable for the forwarded clocks
//   clk25m_on         : ODDR2 CE enable
//   dcm_locked        : DCM LOCKED (asynchronous)
//   dcm_progdone      : DCM PROGDONE (asynchronous)
//   dcm_progen        : DCM PROGEN
//   dcm_progdata      : DCM PROGDATA
//   dcm_rst           : DCM RST
module dcm_prog_ctrl
  import dcm_prog_pkg::*;
#(
  parameter int GATE_CYC    = 16,
  parameter int SETTLE_CYC  = 1024,
  parameter int TIMEOUT_CYC = 65535,
  parameter int RST_CYC     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_req,
  input  logic [7:0] cfg_m_m1,
  input  logic [7:0] cfg_d_m1,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic       busy,
  input  logic       clk_on_req,
  output logic       clk25m_on,
  input  logic       dcm_locked,
  input  logic       dcm_progdone,
  output logic       dcm_progen,
  output logic       dcm_progdata,
  output logic       dcm_rst
);

  localparam logic [15:0] GATE_LAST    = 16'(GATE_CYC - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] RST_LAST     = 16'(RST_CYC - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_LEN - 1);

  state_t               state;
  state_t               state_next;
  logic [15:0]          cnt;
  logic [7:0]           m_reg;
  logic [7:0]           d_reg;
  logic                 retried;
  logic                 accept;
  logic                 ack_next;
  logic                 err_next;
  logic                 locked_meta;
  logic                 locked_s;
  logic                 done_meta;
  logic                 done_s;
  logic                 sh_load;
  logic [FRAME_LEN-1:0] sh_frame;
  logic                 sh_busy;
  logic                 sh_last;
  logic                 sh_data;

  // Two-flop synchronisers for the DCM status pins; nothing else in the
  // block looks at the raw inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
      done_meta   <= 1'b0;
      done_s      <= 1'b0;
    end else begin
      locked_meta <= dcm_locked;
      locked_s    <= locked_meta;
      done_meta   <= dcm_progdone;
      done_s      <= done_meta;
    end
  end

  // One frame serialiser is reused for both the D and the M load.
  dcm_prog_shifter u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .frame (sh_frame),
    .busy  (sh_busy),
    .last  (sh_last),
    .sdata (sh_data)
  );

  // Next-state logic. Frames are loaded on the last cycle of the preceding
  // GATE/GAP state so PROGEN rises exactly on entry to LOAD_D/LOAD_M, and the
  // LOAD states end on the shifter's final bit. While cfg_ack is high the
  // host has not yet had a chance to drop cfg_req, so IDLE ignores it then.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    sh_load    = 1'b0;
    sh_frame   = (state == ST_GAP_D) ? build_frame(CMD_LOAD_M, m_reg)
                                     : build_frame(CMD_LOAD_D, d_reg);
    case (state)
      ST_IDLE: begin
        if (cfg_req && !cfg_ack) begin
          if (cfg_m_m1 == 8'd0) begin
            ack_next = 1'b1;
            err_next = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = ST_GATE;
          end
        end
      end
      ST_GATE: begin
        if (cnt == GATE_LAST) begin
          sh_load    = 1'b1;
          state_next = ST_LOAD_D;
        end
      end
      ST_LOAD_D: if (sh_last) state_next = ST_GAP_D;
      ST_GAP_D: begin
        if (cnt == GAP_LAST) begin
          sh_load    = 1'b1;
          state_next = ST_LOAD_M;
        end
      end
      ST_LOAD_M: if (sh_last) state_next = ST_GAP_M;
      ST_GAP_M:  if (cnt == GAP_LAST) state_next = ST_GO;
      ST_GO:     state_next = ST_WAIT_DONE;
      ST_WAIT_DONE, ST_WAIT_LOCK: begin
        if ((state == ST_WAIT_DONE) ? done_s : locked_s) begin
          state_next = (state == ST_WAIT_DONE) ? ST_WAIT_LOCK : ST_SETTLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retried) begin
            state_next = ST_IDLE;
            ack_next   = 1'b1;
            err_next   = 1'b1;
          end else begin
            state_next = ST_RECOVER;
          end
        end
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_next = ST_WAIT_LOCK;
        end else if (cnt == SETTLE_LAST) begin
          state_next = ST_IDLE;
          ack_next   = 1'b1;
        end
      end
      ST_RECOVER: if (cnt == RST_LAST) state_next = ST_WAIT_LOCK;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register, shared cycle counter (cleared on every state change),
  // latched M-1/D-1, retry flag and the registered host-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      m_reg     <= '0;
      d_reg     <= '0;
      retried   <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      clk25m_on <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= (state_next != state) ? 16'd0 : cnt + 16'd1;
      cfg_ack   <= ack_next;
      cfg_err   <= err_next;
      clk25m_on <= clk_on_req & locked_s & (state == ST_IDLE);
      if (accept) begin
        m_reg   <= cfg_m_m1;
        d_reg   <= cfg_d_m1;
        retried <= 1'b0;
      end else if (state == ST_RECOVER) begin
        retried <= 1'b1;
      end
    end
  end

  assign busy         = (state != ST_IDLE);
  assign dcm_progen   = sh_busy | (state == ST_GO);
  assign dcm_progdata = sh_data;
  assign dcm_rst      = (state == ST_RECOVER);

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// tb_dcm_prog_ctrl
// Self-checking bench for dcm_prog_ctrl. Expected PROGEN/PROGDATA sequences and
// expected ack/err results are queued when a request is issued and consumed
// by a monitor as the DCM port produces them. The timeout is shortened so the
// run stays short; all other timing parameters keep their normal values.
module tb_dcm_prog_ctrl;

  localparam int GATE_CYC    = 16;
  localparam int SETTLE_CYC  = 1024;
  localparam int TIMEOUT_CYC = 600;
  localparam int RST_CYC     = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_req;
  logic [7:0] cfg_m_m1;
  logic [7:0] cfg_d_m1;
  logic       cfg_ack;
  logic       cfg_err;
  logic       busy;
  logic       clk_on_req;
  logic       clk25m_on;
  logic       dcm_locked;
  logic       dcm_progdone;
  logic       dcm_progen;
  logic       dcm_progdata;
  logic       dcm_rst;

  int         compared   = 0;
  int         mismatched = 0;
  int         rst_cycles = 0;
  logic [1:0] prog_q[$];
  logic       ack_q[$];
  logic       in_seq = 1'b0;
  logic [1:0] mon_exp;
  logic       mon_err;

  dcm_prog_ctrl #(
    .GATE_CYC    (GATE_CYC),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RST_CYC     (RST_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_req      (cfg_req),
    .cfg_m_m1     (cfg_m_m1),
    .cfg_d_m1     (cfg_d_m1),
    .cfg_ack      (cfg_ack),
    .cfg_err      (cfg_err),
    .busy         (busy),
    .clk_on_req   (clk_on_req),
    .clk25m_on    (clk25m_on),
    .dcm_locked   (dcm_locked),
    .dcm_progdone (dcm_progdone),
    .dcm_progen   (dcm_progen),
    .dcm_progdata (dcm_progdata),
    .dcm_rst      (dcm_rst)
  );

  // 100 MHz-style free-running clock; the DUT samples on the rising edge and
  // the bench looks at outputs on the falling edge.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Queue the PROGEN/PROGDATA pattern of a full programming sequence:
  // D frame, gap, M frame, gap, GO. Then raise the request.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] d,
                               input logic expect_err);
    if (m != 8'd0) begin
      prog_q.push_back(2'b11);
      prog_q.push_back(2'b10);
      for (int i = 0; i < 8; i++) prog_q.push_back({1'b1, d[i]});
      repeat (2) prog_q.push_back(2'b00);
      prog_q.push_back(2'b11);
      prog_q.push_back(2'b11);
      for (int i = 0; i < 8; i++) prog_q.push_back({1'b1, m[i]});
      repeat (2) prog_q.push_back(2'b00);
      prog_q.push_back(2'b10);
    end
    ack_q.push_back(expect_err);
    @(negedge clk);
    cfg_m_m1 = m;
    cfg_d_m1 = d;
    cfg_req  = 1'b1;
  endtask

  task automatic waitProgStart(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dcm_progen && n < 200);
    checkOutput("progen_start", dcm_progen, 1);
  endtask

  // Returns at the negedge of the GO cycle, with the modelled DCM having
  // dropped LOCKED and PROGDONE when programming began.
  task automatic goToGo(output int gate_n);
    waitProgStart(gate_n);
    dcm_progdone = 1'b0;
    dcm_locked   = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic waitAck(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_ack && n < limit);
    if (!cfg_ack) checkOutput("ack_wait", cfg_ack, 1);
    cfg_req = 1'b0;
  endtask

  // Scoreboard monitor: once PROGEN rises, each cycle is compared against the
  // next queued entry until the queue drains; PROGEN outside a queued
  // sequence, data without PROGEN, or an unexpected ack are all errors.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_seq || dcm_progen) begin
        if (prog_q.size() == 0) begin
          checkOutput("spurious_progen", dcm_progen, 0);
          in_seq = 1'b0;
        end else begin
          mon_exp = prog_q.pop_front();
          checkOutput("progen", dcm_progen, mon_exp[1]);
          checkOutput("progdata", dcm_progdata, mon_exp[0]);
          in_seq = (prog_q.size() != 0);
        end
      end else if (dcm_progdata) begin
        checkOutput("data_without_en", dcm_progdata, 0);
      end
      if (cfg_ack) begin
        if (ack_q.size() == 0) begin
          checkOutput("unexpected_ack", cfg_ack, 0);
        end else begin
          mon_err = ack_q.pop_front();
          checkOutput("ack_err", cfg_err, mon_err);
        end
      end else if (cfg_err) begin
        checkOutput("err_without_ack", cfg_err, 0);
      end
      if (dcm_rst) rst_cycles++;
    end
  end

  // Hard stop in case some wait never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence of scenarios.
  initial begin
    int n;
    int w;
    int rst_before;
    rst_n        = 1'b0;
    cfg_req      = 1'b0;
    cfg_m_m1     = 8'd0;
    cfg_d_m1     = 8'd0;
    clk_on_req   = 1'b0;
    dcm_locked   = 1'b0;
    dcm_progdone = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", cfg_ack, 0);
    checkOutput("rst_err", cfg_err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_clk_on", clk25m_on, 0);
    checkOutput("rst_progen", dcm_progen, 0);
    checkOutput("rst_progdata", dcm_progdata, 0);
    checkOutput("rst_dcm_rst", dcm_rst, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] clock enable after lock");
    clk_on_req = 1'b1;
    dcm_locked = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clk25m_on && n < 20);
    checkOutput("clk_on_latency", n, 3);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] normal programming M-1=1 D-1=0");
    applyStimulus(8'd1, 8'd0, 1'b0);
    goToGo(n);
    checkOutput("gate_len", n, GATE_CYC + 1);
    checkOutput("clk_gated", clk25m_on, 0);
    checkOutput("busy_in_go", busy, 1);
    repeat (50) @(negedge clk);
    dcm_progdone = 1'b1;
    repeat (200) @(negedge clk);
    dcm_locked = 1'b1;
    waitAck(3000, n);
    checkOutput("settle_len", n, SETTLE_CYC + 3);
    @(negedge clk);
    checkOutput("clk_restored", clk25m_on, 1);
    checkOutput("busy_after_ack", busy, 0);

    $display("[TB] illegal M rejected");
    applyStimulus(8'd0, 8'd7, 1'b1);
    waitAck(5, n);
    checkOutput("reject_latency", n, 1);
    checkOutput("reject_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("reject_single_ack", cfg_ack, 0);
      checkOutput("reject_idle", busy, 0);
    end

    $display("[TB] lock lost during settle");
    applyStimulus(8'h05, 8'h02, 1'b0);
    goToGo(n);
    checkOutput("gate_len2", n, GATE_CYC + 1);
    repeat (50) @(negedge clk);
    dcm_progdone = 1'b1;
    repeat (200) @(negedge clk);
    dcm_locked = 1'b1;
    repeat (100) @(negedge clk);
    rst_before = rst_cycles;
    dcm_locked = 1'b0;
    repeat (5) @(negedge clk);
    dcm_locked = 1'b1;
    waitAck(3000, n);
    checkOutput("relock_settle", n, SETTLE_CYC + 3);
    checkOutput("relock_no_rst", rst_cycles, rst_before);

    $display("[TB] DCM never answers");
    applyStimulus(8'h03, 8'h01, 1'b1);
    goToGo(n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dcm_rst && n < 3000);
    checkOutput("done_timeout", n, TIMEOUT_CYC + 1);
    w = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!dcm_rst) break;
      w++;
    end
    checkOutput("rst_width", w, RST_CYC);
    waitAck(3000, n);
    checkOutput("lock_timeout", n, TIMEOUT_CYC);
    checkOutput("fail_busy", busy, 0);
    @(negedge clk);
    checkOutput("clk_stays_off", clk25m_on, 0);
    dcm_locked = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clk25m_on && n < 20);
    checkOutput("clk_on_relock", n, 3);

    $display("[TB] reset in the middle of the M frame");
    applyStimulus(8'h02, 8'h03, 1'b0);
    waitProgStart(n);
    repeat (15) @(negedge clk);
    rst_n   = 1'b0;
    cfg_req = 1'b0;
    #1;
    checkOutput("rst_progen_drop", dcm_progen, 0);
    checkOutput("rst_progdata_drop", dcm_progdata, 0);
    checkOutput("rst_busy_drop", busy, 0);
    prog_q.delete();
    ack_q.delete();
    in_seq = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fresh request after reset");
    applyStimulus(8'hA6, 8'h5B, 1'b0);
    goToGo(n);
    checkOutput("gate_len3", n, GATE_CYC + 1);
    repeat (50) @(negedge clk);
    dcm_progdone = 1'b1;
    repeat (200) @(negedge clk);
    dcm_locked = 1'b1;
    waitAck(3000, n);
    checkOutput("fresh_settle", n, SETTLE_CYC + 3);
    repeat (2) @(negedge clk);

    checkOutput("prog_q_drained", prog_q.size(), 0);
    checkOutput("ack_q_drained", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
